// File: rtl/fam_pkg.sv
// Shared types and constants for the sequential single-precision adder.
package fam_pkg;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MAN_W     = 23;
  localparam int unsigned EXP_MAX   = 255;
  localparam int unsigned ALIGN_CAP = 25;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, FIX, NORM, PACK} state_t;
endpackage

// File: rtl/fam_neg25.sv
// Two's-complement negator: bitwise invert followed by a half-adder increment chain.
module fam_neg25 #(
  parameter int unsigned W = 25
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  always_comb begin
    logic c;
    c = 1'b1;
    y = '0;
    for (int unsigned i = 0; i < W; i++) begin
      y[i] = ~x[i] ^ c;
      c    = ~x[i] & c;
    end
  end
endmodule

// File: rtl/fam_add_seq.sv
// Multi-cycle IEEE-754 single-precision adder: one shift per cycle for align/normalize,
// with a single negator shared between the subtract and sign-fix phases.
module fam_add_seq
  import fam_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned SW = MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;

  state_t           state;
  logic             sa, sign, eff_add;
  logic [EW-1:0]    ex;
  logic [MW-1:0]    ma, mb;
  logic [EXP_W-1:0] diff;
  logic [SW-1:0]    sum;

  logic [EXP_W-1:0] ea_in, eb_in, ebig, esmall, diff_raw;
  logic [MW-1:0]    ma_in, mb_in, mbig, msmall;
  logic             swap, sbig;
  logic [SW-1:0]    neg_in, neg_out, add_b, add_out;

  always_comb begin
    ea_in    = a[EXP_W+MAN_W-1:MAN_W];
    eb_in    = b[EXP_W+MAN_W-1:MAN_W];
    ma_in    = (ea_in == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    mb_in    = (eb_in == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    swap     = eb_in > ea_in;
    ebig     = swap ? eb_in : ea_in;
    esmall   = swap ? ea_in : eb_in;
    mbig     = swap ? mb_in : ma_in;
    msmall   = swap ? ma_in : mb_in;
    sbig     = swap ? b[EXP_W+MAN_W] : a[EXP_W+MAN_W];
    diff_raw = ebig - esmall;
  end

  // The negator sees the running sum only in FIX; otherwise it serves the subtract in ADD.
  assign neg_in  = (state == FIX) ? sum : {1'b0, mb};
  assign add_b   = eff_add ? {1'b0, mb} : neg_out;
  assign add_out = {1'b0, ma} + add_b;

  fam_neg25 #(.W(SW)) u_neg (
    .x (neg_in),
    .y (neg_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      sa      <= 1'b0;
      sign    <= 1'b0;
      eff_add <= 1'b0;
      ex      <= '0;
      ma      <= '0;
      mb      <= '0;
      diff    <= '0;
      sum     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa      <= sbig;
            eff_add <= (a[EXP_W+MAN_W] == b[EXP_W+MAN_W]);
            ex      <= {2'b00, ebig};
            ma      <= mbig;
            if (diff_raw >= EXP_W'(ALIGN_CAP)) begin
              mb   <= '0;
              diff <= '0;
            end else begin
              mb   <= msmall;
              diff <= diff_raw;
            end
            busy  <= 1'b1;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (diff == '0) begin
            state <= ADD;
          end else begin
            mb   <= mb >> 1;
            diff <= diff - 1'b1;
          end
        end
        ADD: begin
          sum <= add_out;
          if (!eff_add && add_out[SW-1]) begin
            state <= FIX;
          end else begin
            sign  <= sa;
            state <= NORM;
          end
        end
        FIX: begin
          sum   <= neg_out;
          sign  <= ~sa;
          state <= NORM;
        end
        NORM: begin
          // A zero sum keeps its sign only on the same-sign path, so -0 + -0 stays -0.
          if (sum == '0) begin
            if (!eff_add) sign <= 1'b0;
            ex    <= '0;
            state <= PACK;
          end else if (eff_add && sum[SW-1]) begin
            sum   <= sum >> 1;
            ex    <= ex + 1'b1;
            state <= PACK;
          end else if (sum[MAN_W]) begin
            state <= PACK;
          end else if (ex <= EW'(1)) begin
            sum   <= '0;
            ex    <= '0;
            state <= PACK;
          end else begin
            sum <= sum << 1;
            ex  <= ex - 1'b1;
          end
        end
        PACK: begin
          if (ex >= EW'(EXP_MAX))
            result <= {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else
            result <= {sign, ex[EXP_W-1:0], sum[MAN_W-1:0]};
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fam_add_seq.sv
// Directed scoreboard bench for fam_add_seq: expected sum and latency are queued at start
// and checked when done pulses.
module tb_fam_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  fam_add_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Launch one add; optionally pulse start again while busy, which must be ignored.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input int el, input bit poke);
    exp_t e;
    int   lat;
    bit   got;
    int   extra;
    sb.push_back('{er, el});
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) got = 1'b1;
      if (poke && lat == 1) begin
        start = 1'b1; a = 32'h40400000; b = 32'h40400000;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_timeout"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
    end
    extra = 0;
    for (int i = 0; i < (poke ? 8 : 1); i++) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    chk({tag, "_no_extra_done"}, extra, 32'd0);
    chk({tag, "_result_held"}, result, e.res);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 4, 1'b0);
    do_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 4, 1'b0);
    do_op("fix_path",     32'h3F800000, 32'hBFC00000, 32'hBF000000, 6, 1'b0);
    do_op("align24",      32'h4B800000, 32'h3F800000, 32'h4B800000, 28, 1'b0);
    do_op("align_cap",    32'h4C000000, 32'h3F800000, 32'h4C000000, 4, 1'b0);
    do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4, 1'b0);
    do_op("swap",         32'h3F800000, 32'h40400000, 32'h40800000, 5, 1'b0);
    do_op("norm_left2",   32'h3F800000, 32'hBF400000, 32'h3E800000, 7, 1'b0);
    do_op("denorm_flush", 32'h00000001, 32'h3F800000, 32'h3F800000, 4, 1'b0);
    do_op("neg_zeros",    32'h80000000, 32'h80000000, 32'h80000000, 4, 1'b0);
    do_op("start_busy",   32'h3F800000, 32'h3F800000, 32'h40000000, 4, 1'b1);

    // Abort a long alignment with an asynchronous reset.
    @(negedge clk);
    a = 32'h4B800000; b = 32'h3F800000; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 32'd0);
    chk("abort_idle", {31'b0, busy}, 32'd0);

    do_op("after_rst",    32'h3F800000, 32'hBFC00000, 32'hBF000000, 6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
